// File: rtl/spi_ram_arbiter.sv
// Round-robin, whole-transaction arbiter sharing one SPI RAM pin set between two requesters.
// Optional ownership watchdog is compiled in when ARB_TIMEOUT_EN is defined.
module spi_ram_arbiter #(
  parameter int MIN_DESELECT = 2,
  parameter int TIMEOUT      = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_select,
  input  logic       req0_mosi,
  input  logic       req0_clk_en,
  output logic       req0_miso,
  output logic       req0_wait,
  input  logic       req1_select,
  input  logic       req1_mosi,
  input  logic       req1_clk_en,
  output logic       req1_miso,
  output logic       req1_wait,
  output logic       spi_select,
  output logic       spi_mosi,
  output logic       spi_clk_en,
  input  logic       spi_miso,
  output logic [1:0] grant,
  output logic       timeout_err
);

  localparam int GAP_W = (MIN_DESELECT > 1) ? $clog2(MIN_DESELECT) : 1;

  if (MIN_DESELECT < 1 || TIMEOUT < 1) begin : g_param_check
    $error("spi_ram_arbiter: MIN_DESELECT and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  state_t           state, state_nx;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;
  logic             last, last_nx;
  logic             select_nx, mosi_nx, clk_en_nx;
  logic [1:0]       grant_nx;
  logic [1:0]       eligible;
  logic             pick;
  logic             owning, own_select, own_mosi, own_clk_en;
  logic             timeout_hit;

  assign owning     = (state == OWN0) || (state == OWN1);
  assign own_select = (state == OWN1) ? req1_select : req0_select;
  assign own_mosi   = (state == OWN1) ? req1_mosi   : req0_mosi;
  assign own_clk_en = (state == OWN1) ? req1_clk_en : req0_clk_en;

  // pick = 1 selects req1; on contention the requester not granted last wins
  assign pick = eligible[1] & (~eligible[0] | ~last);

  assign req0_miso = grant[0] & spi_miso;
  assign req1_miso = grant[1] & spi_miso;
  assign req0_wait = !req0_select && !grant[0];
  assign req1_wait = !req1_select && !grant[1];

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TO_W-1:0] own_cnt;
  logic [1:0]      locked;
  logic            err;

  // A natural release on the final cycle is not counted as a timeout
  assign timeout_hit = owning && !own_select && (own_cnt == TO_W'(TIMEOUT - 1));
  assign eligible    = ~{req1_select, req0_select} & ~locked;
  assign timeout_err = err;

  // A timed-out requester stays locked out until it has raised select once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_cnt <= '0;
      locked  <= 2'b00;
      err     <= 1'b0;
    end else begin
      own_cnt   <= owning ? own_cnt + TO_W'(1) : '0;
      err       <= err | timeout_hit;
      locked[0] <= (timeout_hit && state == OWN0) || (locked[0] && !req0_select);
      locked[1] <= (timeout_hit && state == OWN1) || (locked[1] && !req1_select);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign eligible    = ~{req1_select, req0_select};
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      spi_select <= 1'b1;
      spi_mosi   <= 1'b0;
      spi_clk_en <= 1'b0;
      gap_cnt    <= '0;
      last       <= 1'b1;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      spi_select <= select_nx;
      spi_mosi   <= mosi_nx;
      spi_clk_en <= clk_en_nx;
      gap_cnt    <= gap_cnt_nx;
      last       <= last_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    select_nx  = spi_select;
    mosi_nx    = spi_mosi;
    clk_en_nx  = spi_clk_en;
    gap_cnt_nx = gap_cnt;
    last_nx    = last;
    case (state)
      IDLE: begin
        // The winner's first bit is loaded on the grant edge so pins lag by one cycle
        if (|eligible) begin
          state_nx  = pick ? OWN1 : OWN0;
          grant_nx  = pick ? 2'b10 : 2'b01;
          last_nx   = pick;
          select_nx = 1'b0;
          mosi_nx   = pick ? req1_mosi   : req0_mosi;
          clk_en_nx = pick ? req1_clk_en : req0_clk_en;
        end
      end
      OWN0, OWN1: begin
        if (own_select || timeout_hit) begin
          state_nx   = GAP;
          grant_nx   = 2'b00;
          select_nx  = 1'b1;
          clk_en_nx  = 1'b0;
          gap_cnt_nx = GAP_W'(MIN_DESELECT - 1);
        end else begin
          select_nx = 1'b0;
          mosi_nx   = own_mosi;
          clk_en_nx = own_clk_en;
        end
      end
      GAP: begin
        // Together with the IDLE cycle this holds select high MIN_DESELECT cycles
        select_nx = 1'b1;
        clk_en_nx = 1'b0;
        if (gap_cnt <= GAP_W'(1)) state_nx = IDLE;
        if (gap_cnt != '0) gap_cnt_nx = gap_cnt - GAP_W'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: randomized requester traffic checked against a transaction-level model.
module tb_spi_ram_arbiter;

  localparam int MIN_DESELECT = 2;
  localparam int TIMEOUT      = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic r0_sel = 1'b1, r0_mosi = 1'b0, r0_clk = 1'b0;
  logic r1_sel = 1'b1, r1_mosi = 1'b0, r1_clk = 1'b0;
  logic spi_miso = 1'b0;
  logic req0_miso, req0_wait, req1_miso, req1_wait;
  logic spi_select, spi_mosi, spi_clk_en, timeout_err;
  logic [1:0] grant;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.MIN_DESELECT(MIN_DESELECT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_select(r0_sel), .req0_mosi(r0_mosi), .req0_clk_en(r0_clk),
    .req0_miso(req0_miso), .req0_wait(req0_wait),
    .req1_select(r1_sel), .req1_mosi(r1_mosi), .req1_clk_en(r1_clk),
    .req1_miso(req1_miso), .req1_wait(req1_wait),
    .spi_select(spi_select), .spi_mosi(spi_mosi), .spi_clk_en(spi_clk_en),
    .spi_miso(spi_miso), .grant(grant), .timeout_err(timeout_err)
  );

  // Reference model: owner id (-1 = none), cycles select has been high since the last release
  int   m_owner, m_high, m_last, m_cnt;
  logic m_sel, m_mosi, m_clk, m_err;
  logic [1:0] m_lock;
  int   n_owner, n_high, n_last, n_cnt;
  logic n_sel, n_mosi, n_clk, n_err;
  logic [1:0] n_lock;
  logic o_sel, o_mosi, o_clk, want0, want1;

  always_comb begin
    n_owner = m_owner; n_high = m_high; n_last = m_last; n_cnt = m_cnt;
    n_sel = m_sel; n_mosi = m_mosi; n_clk = m_clk; n_err = m_err; n_lock = m_lock;
    o_sel = 1'b1; o_mosi = 1'b0; o_clk = 1'b0; want0 = 1'b0; want1 = 1'b0;
    if (r0_sel) n_lock[0] = 1'b0;
    if (r1_sel) n_lock[1] = 1'b0;
    if (m_owner >= 0) begin
      o_sel  = (m_owner == 0) ? r0_sel  : r1_sel;
      o_mosi = (m_owner == 0) ? r0_mosi : r1_mosi;
      o_clk  = (m_owner == 0) ? r0_clk  : r1_clk;
      n_cnt  = m_cnt + 1;
      if (o_sel || (TO_EN && n_cnt >= TIMEOUT)) begin
        if (!o_sel) begin
          n_err = 1'b1;
          if (m_owner == 0) n_lock[0] = 1'b1; else n_lock[1] = 1'b1;
        end
        n_owner = -1; n_sel = 1'b1; n_clk = 1'b0; n_high = 1;
      end else begin
        n_sel = 1'b0; n_mosi = o_mosi; n_clk = o_clk;
      end
    end else begin
      want0 = !r0_sel && !m_lock[0];
      want1 = !r1_sel && !m_lock[1];
      if (m_high >= MIN_DESELECT && (want0 || want1)) begin
        n_owner = (want0 && want1) ? 1 - m_last : (want1 ? 1 : 0);
        n_last  = n_owner;
        n_cnt   = 0;
        n_sel   = 1'b0;
        n_mosi  = (n_owner == 1) ? r1_mosi : r0_mosi;
        n_clk   = (n_owner == 1) ? r1_clk  : r0_clk;
      end else if (m_high < MIN_DESELECT) begin
        n_high = m_high + 1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1; m_high <= MIN_DESELECT; m_last <= 1; m_cnt <= 0;
      m_sel <= 1'b1; m_mosi <= 1'b0; m_clk <= 1'b0; m_err <= 1'b0; m_lock <= 2'b00;
    end else begin
      m_owner <= n_owner; m_high <= n_high; m_last <= n_last; m_cnt <= n_cnt;
      m_sel <= n_sel; m_mosi <= n_mosi; m_clk <= n_clk; m_err <= n_err; m_lock <= n_lock;
    end
  end

  logic [1:0] exp_grant;
  logic [9:0] exp, obs;
  assign exp_grant = (m_owner == 0) ? 2'b01 : ((m_owner == 1) ? 2'b10 : 2'b00);
  assign exp = {m_sel, m_mosi, m_clk, exp_grant,
                (m_owner == 0) & spi_miso, !r0_sel && (m_owner != 0),
                (m_owner == 1) & spi_miso, !r1_sel && (m_owner != 1), m_err};
  assign obs = {spi_select, spi_mosi, spi_clk_en, grant,
                req0_miso, req0_wait, req1_miso, req1_wait, timeout_err};

  task automatic drive(input logic s0, input logic s1);
    r0_sel = s0; r1_sel = s1;
    r0_mosi = 1'($urandom_range(0, 1)); r0_clk = 1'($urandom_range(0, 1));
    r1_mosi = 1'($urandom_range(0, 1)); r1_clk = 1'($urandom_range(0, 1));
    spi_miso = 1'($urandom_range(0, 1));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    vectors++;
    if (obs !== 10'b1_0_0_00_0_0_0_0_0) begin
      errors++; $display("FAIL reset_state: got %b want %b", obs, 10'b1_0_0_00_0_0_0_0_0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_owner();
    int lim;
    lim = TO_EN ? TIMEOUT : 40;
    apply_reset();
    for (int i = 1; i <= 40; i++) begin
      drive(1'b0, 1'b1);
      cyc();
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL single[%0d]: got %b want %b", i, obs, exp); end
      if (i <= lim) begin
        vectors++;
        if ({grant, req0_wait, req1_miso, spi_select, spi_mosi} !== {2'b01, 1'b0, 1'b0, 1'b0, r0_mosi}) begin
          errors++;
          $display("FAIL single_pins[%0d]: got g=%b w=%b m1=%b s=%b mo=%b want g=01 w=0 m1=0 s=0 mo=%b",
                   i, grant, req0_wait, req1_miso, spi_select, spi_mosi, r0_mosi);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1);
      cyc();
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL single_rel[%0d]: got %b want %b", i, obs, exp); end
    end
  endtask

  task automatic test_contention();
    int high;
    apply_reset();
    drive(1'b0, 1'b0);
    cyc();
    vectors++;
    if ({grant, req1_wait} !== 3'b01_1) begin
      errors++; $display("FAIL contend_first: got g=%b w1=%b want g=01 w1=1", grant, req1_wait);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0);
      cyc();
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL contend_own[%0d]: got %b want %b", i, obs, exp); end
    end
    high = 0;
    for (int i = 0; i < 10 && grant !== 2'b10; i++) begin
      drive(1'b1, 1'b0);
      cyc();
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL contend_gap[%0d]: got %b want %b", i, obs, exp); end
      if (spi_select === 1'b1 && grant === 2'b00) high++;
    end
    vectors++;
    if (grant !== 2'b10 || high != MIN_DESELECT) begin
      errors++; $display("FAIL contend_gap_len: got g=%b high=%0d want g=10 high=%0d", grant, high, MIN_DESELECT);
    end
    drive(1'b1, 1'b1);
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [1:0] expg, prev;
    logic s0, s1;
    int seen, hold, len;
    apply_reset();
    expg = 2'b01; prev = 2'b00; seen = 0; hold = 0; len = $urandom_range(2, 6);
    for (int i = 0; i < 300 && seen < 4; i++) begin
      s0 = (grant === 2'b01 && hold >= len);
      s1 = (grant === 2'b10 && hold >= len);
      drive(s0, s1);
      cyc();
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL b2b[%0d]: got %b want %b", i, obs, exp); end
      vectors++;
      if (grant === 2'b11 || (spi_select === 1'b0 && grant === 2'b00)) begin
        errors++; $display("FAIL b2b_overlap[%0d]: got g=%b s=%b want single owner", i, grant, spi_select);
      end
      if (grant !== 2'b00 && prev === 2'b00) begin
        vectors++;
        if (grant !== expg) begin errors++; $display("FAIL b2b_order[%0d]: got %b want %b", seen, grant, expg); end
        expg = {expg[0], expg[1]};
        seen++; hold = 0; len = $urandom_range(2, 6);
      end else if (grant !== 2'b00) begin
        hold++;
      end
      prev = grant;
    end
    vectors++;
    if (seen != 4) begin errors++; $display("FAIL b2b_count: got %0d grants want 4", seen); end
  endtask

  task automatic test_pulse_discard();
    logic [1:0] s1_pat [13];
    apply_reset();
    for (int i = 0; i < 13; i++) s1_pat[i] = (i == 3) ? 2'b00 : ((i < 7) ? 2'b01 : 2'b11);
    for (int i = 0; i < 13; i++) begin
      drive(s1_pat[i][1], s1_pat[i][0]);
      cyc();
      vectors++;
      if (obs !== exp || grant[1] !== 1'b0) begin
        errors++; $display("FAIL pulse[%0d]: got %b want %b (no req1 grant)", i, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic s0, s1;
    apply_reset();
    s0 = 1'b1; s1 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) s0 = ~s0;
      if ($urandom_range(0, 5) == 0) s1 = ~s1;
      drive(s0, s1);
      cyc();
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL random[%0d]: got %b want %b", i, obs, exp); end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] want;
    apply_reset();
    for (int i = 1; i <= 30; i++) begin
      drive(1'b0, 1'b1);
      cyc();
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL timeout[%0d]: got %b want %b", i, obs, exp); end
      if (TO_EN) want = {(i <= TIMEOUT) ? 2'b01 : 2'b00, (i > TIMEOUT), (i > TIMEOUT)};
      else       want = 4'b01_0_0;
      vectors++;
      if ({grant, timeout_err, req0_wait} !== want) begin
        errors++; $display("FAIL timeout_flags[%0d]: got %b want %b", i, {grant, timeout_err, req0_wait}, want);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1);
      cyc();
      vectors++;
      if (obs !== exp || req0_wait !== 1'b0 || timeout_err !== TO_EN) begin
        errors++; $display("FAIL timeout_rel[%0d]: got %b want %b err=%b", i, obs, exp, TO_EN);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1);
      cyc();
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL timeout_regrant[%0d]: got %b want %b", i, obs, exp); end
    end
    vectors++;
    if (grant !== 2'b01) begin errors++; $display("FAIL timeout_regrant: got g=%b want 01", grant); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1);
      r0_clk = 1'b1;
      cyc();
    end
    vectors++;
    if ({spi_select, spi_clk_en, grant} !== 4'b0_1_01) begin
      errors++; $display("FAIL mid_pre: got %b want 0101", {spi_select, spi_clk_en, grant});
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({spi_select, spi_clk_en, grant} !== 4'b1_0_00) begin
      errors++; $display("FAIL mid_reset: got %b want 1000", {spi_select, spi_clk_en, grant});
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1);
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_contention();
    test_back_to_back();
    test_pulse_discard();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
